banco_registradores_renome: RTL and testbench

- Parametrised architectural register file with a register-status (rename) table for the Tomasulo core.
- Each register holds a data value and a producer tag. Tag 0 means the value is valid; a nonzero tag names the reservation station that will produce the value.
- Dispatch has two operand read ports and one rename write port. A common data bus (CDB) broadcast retires tags and writes values. A flush clears all pending tags.
- Sits between the issue unit and the reservation stations; the CDB arbiter drives the broadcast inputs.

---
 rtl/banco_registradores_renome.sv | 111 +++++++++++
 tb/tb_banco_registradores_renome.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/banco_registradores_renome.sv
// Register file with rename (register-status) table for the Tomasulo core.
// Ports: clock/reset_n (sync, active-low); two operand read ports (data+tag);
// rename write port (ren_en/ren_addr/ren_tag); CDB broadcast (cdb_valid/
// cdb_tag/cdb_data); flush; busy_count (registered); ren_err (sticky).
// Optional macro BANCO_CDB_BYPASS_EN: read ports forward same-cycle CDB.
module banco_registradores_renome #(
  parameter int NREGS  = 8,
  parameter int DATA_W = 16,
  parameter int TAG_W  = 3,
  parameter int ADDR_W = $clog2(NREGS)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [TAG_W-1:0]  rd_tag_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic [TAG_W-1:0]  rd_tag_b,
  input  logic              ren_en,
  input  logic [ADDR_W-1:0] ren_addr,
  input  logic [TAG_W-1:0]  ren_tag,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  input  logic              flush,
  output logic [ADDR_W:0]   busy_count,
  output logic              ren_err
);

  localparam int CW = ADDR_W + 1;

  logic [DATA_W-1:0] data_q   [NREGS];
  logic [TAG_W-1:0]  tag_q    [NREGS];
  logic [DATA_W-1:0] data_nxt [NREGS];
  logic [TAG_W-1:0]  tag_nxt  [NREGS];
  logic [CW-1:0]     busy_nxt;

  logic              cdb_ok;
  logic              ren_ok;
  logic              ren_bad;
  logic [NREGS-1:0]  cdb_hit;
  logic [NREGS-1:0]  ren_hit;

  assign cdb_ok  = cdb_valid && (cdb_tag != '0);
  assign ren_ok  = ren_en && (ren_tag != '0);
  assign ren_bad = ren_en && (ren_tag == '0);

  // Next-state for every entry; busy_count is counted from the
  // next-state tags so it lines up with the table after the edge.
  always_comb begin
    busy_nxt = '0;
    cdb_hit  = '0;
    ren_hit  = '0;
    for (int i = 0; i < NREGS; i++) begin
      cdb_hit[i]  = cdb_ok && (tag_q[i] == cdb_tag);
      ren_hit[i]  = ren_ok && (ren_addr == ADDR_W'(i));
      data_nxt[i] = data_q[i];
      tag_nxt[i]  = tag_q[i];
      // A re-rename to the broadcasting tag keeps the entry waiting,
      // so the stale broadcast value must not land there.
      if (cdb_hit[i] && !(ren_hit[i] && ren_tag == cdb_tag))
        data_nxt[i] = cdb_data;
      if (flush)
        tag_nxt[i] = '0;
      else if (ren_hit[i])
        tag_nxt[i] = ren_tag;
      else if (cdb_hit[i])
        tag_nxt[i] = '0;
      if (tag_nxt[i] != '0)
        busy_nxt = busy_nxt + CW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++) begin
        data_q[i] <= '0;
        tag_q[i]  <= '0;
      end
      busy_count <= '0;
      ren_err    <= 1'b0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        data_q[i] <= data_nxt[i];
        tag_q[i]  <= tag_nxt[i];
      end
      busy_count <= busy_nxt;
      if (ren_bad)
        ren_err <= 1'b1;
    end
  end

  always_comb begin
    rd_data_a = data_q[rd_addr_a];
    rd_tag_a  = tag_q[rd_addr_a];
    rd_data_b = data_q[rd_addr_b];
    rd_tag_b  = tag_q[rd_addr_b];
`ifdef BANCO_CDB_BYPASS_EN
    if (cdb_ok && tag_q[rd_addr_a] == cdb_tag) begin
      rd_data_a = cdb_data;
      rd_tag_a  = '0;
    end
    if (cdb_ok && tag_q[rd_addr_b] == cdb_tag) begin
      rd_data_b = cdb_data;
      rd_tag_b  = '0;
    end
`endif
  end

endmodule

// File: tb/tb_banco_registradores_renome.sv
// Directed bench for banco_registradores_renome.
// Expected values are queued at drive time and popped at check time.
module tb_banco_registradores_renome;

  logic        clock;
  logic        reset_n;
  logic [2:0]  rd_addr_a;
  logic [2:0]  rd_addr_b;
  logic [15:0] rd_data_a;
  logic [2:0]  rd_tag_a;
  logic [15:0] rd_data_b;
  logic [2:0]  rd_tag_b;
  logic        ren_en;
  logic [2:0]  ren_addr;
  logic [2:0]  ren_tag;
  logic        cdb_valid;
  logic [2:0]  cdb_tag;
  logic [15:0] cdb_data;
  logic        flush;
  logic [3:0]  busy_count;
  logic        ren_err;

  int n_total;
  int n_pass;
  int n_fail;
  logic [31:0] exp_q[$];

  banco_registradores_renome dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .rd_addr_a  (rd_addr_a),
    .rd_addr_b  (rd_addr_b),
    .rd_data_a  (rd_data_a),
    .rd_tag_a   (rd_tag_a),
    .rd_data_b  (rd_data_b),
    .rd_tag_b   (rd_tag_b),
    .ren_en     (ren_en),
    .ren_addr   (ren_addr),
    .ren_tag    (ren_tag),
    .cdb_valid  (cdb_valid),
    .cdb_tag    (cdb_tag),
    .cdb_data   (cdb_data),
    .flush      (flush),
    .busy_count (busy_count),
    .ren_err    (ren_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic push(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic chk(input string t, input logic [31:0] obs);
    logic [31:0] e;
    n_total++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $error("FAIL %s scoreboard empty obs=%0h", t, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) n_pass++;
      else begin
        n_fail++;
        $error("FAIL %s obs=%0h exp=%0h", t, obs, e);
      end
    end
  endtask

  task automatic idle();
    ren_en    = 1'b0;
    ren_addr  = '0;
    ren_tag   = '0;
    cdb_valid = 1'b0;
    cdb_tag   = '0;
    cdb_data  = '0;
    flush     = 1'b0;
  endtask

  // One clock edge, then drop all strobes and let reads settle.
  task automatic cyc();
    @(posedge clock);
    #1;
    idle();
    #1;
  endtask

  task automatic ren(input logic [2:0] a, input logic [2:0] t);
    ren_en   = 1'b1;
    ren_addr = a;
    ren_tag  = t;
  endtask

  task automatic cdb(input logic [2:0] t, input logic [15:0] d);
    cdb_valid = 1'b1;
    cdb_tag   = t;
    cdb_data  = d;
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    n_fail  = 0;
    reset_n   = 1'b0;
    rd_addr_a = '0;
    rd_addr_b = '0;
    idle();
    cyc();
    cyc();
    reset_n = 1'b1;

    // random activity, then reset must wipe it all
    for (int k = 0; k < 12; k++) begin
      ren_en    = 1'($urandom);
      ren_addr  = 3'($urandom);
      ren_tag   = 3'($urandom);
      cdb_valid = 1'($urandom);
      cdb_tag   = 3'($urandom);
      cdb_data  = 16'($urandom);
      @(posedge clock);
      #1;
    end
    idle();
    reset_n = 1'b0;
    cyc();
    cyc();
    reset_n = 1'b1;
    for (int r = 0; r < 8; r++) begin
      rd_addr_a = 3'(r);
      #1;
      push(0); chk($sformatf("rst_tag_r%0d", r), rd_tag_a);
      push(0); chk($sformatf("rst_data_r%0d", r), rd_data_a);
    end
    push(0); chk("rst_busy", busy_count);
    push(0); chk("rst_err", ren_err);

    // rename r3 -> tag 2
    ren(3, 2);
    cyc();
    rd_addr_a = 3;
    #1;
    push(2); chk("ren_tag_r3", rd_tag_a);
    push(1); chk("ren_busy", busy_count);

    // broadcast tag 2
    cdb(2, 16'hBEEF);
    cyc();
    push(16'hBEEF); chk("cdb_data_r3", rd_data_a);
    push(0);        chk("cdb_tag_r3", rd_tag_a);
    push(0);        chk("cdb_busy", busy_count);

    // multi-match
    ren(1, 4);
    cyc();
    ren(5, 4);
    cyc();
    push(2); chk("mm_busy_pre", busy_count);
    cdb(4, 16'h0055);
    cyc();
    rd_addr_a = 1;
    rd_addr_b = 5;
    #1;
    push(16'h0055); chk("mm_data_r1", rd_data_a);
    push(0);        chk("mm_tag_r1", rd_tag_a);
    push(16'h0055); chk("mm_data_r5", rd_data_b);
    push(0);        chk("mm_tag_r5", rd_tag_b);
    push(0);        chk("mm_busy", busy_count);

    // collision: rename wins tag, CDB writes data
    ren(6, 1);
    cyc();
    ren(6, 3);
    cdb(1, 16'h1234);
    cyc();
    rd_addr_a = 6;
    #1;
    push(16'h1234); chk("col_data_r6", rd_data_a);
    push(3);        chk("col_tag_r6", rd_tag_a);
    push(1);        chk("col_busy", busy_count);

    // rename r0 with the tag being broadcast: r6 clears, r0 waits
    ren(0, 3);
    cdb(3, 16'h7777);
    cyc();
    rd_addr_a = 6;
    rd_addr_b = 0;
    #1;
    push(16'h7777); chk("same_data_r6", rd_data_a);
    push(0);        chk("same_tag_r6", rd_tag_a);
    push(0);        chk("same_data_r0", rd_data_b);
    push(3);        chk("same_tag_r0", rd_tag_b);
    push(1);        chk("same_busy", busy_count);

    // flush with 4 more registers pending
    ren(1, 1); cyc();
    ren(2, 2); cyc();
    ren(4, 5); cyc();
    ren(7, 6); cyc();
    push(5); chk("fl_busy_pre", busy_count);
    flush = 1'b1;
    cyc();
    rd_addr_a = 1;
    rd_addr_b = 6;
    #1;
    push(0);        chk("fl_busy", busy_count);
    push(0);        chk("fl_tag_r1", rd_tag_a);
    push(16'h0055); chk("fl_data_r1", rd_data_a);
    push(16'h7777); chk("fl_data_r6", rd_data_b);

    // flush alongside CDB and rename: data lands, tags cleared
    ren(2, 5);
    cyc();
    ren(3, 7);
    cdb(5, 16'h4242);
    flush = 1'b1;
    cyc();
    rd_addr_a = 2;
    rd_addr_b = 3;
    #1;
    push(16'h4242); chk("flc_data_r2", rd_data_a);
    push(0);        chk("flc_tag_r2", rd_tag_a);
    push(0);        chk("flc_tag_r3", rd_tag_b);
    push(0);        chk("flc_busy", busy_count);

    // rename with tag 0 -> sticky error, table untouched
    ren(4, 0);
    cyc();
    rd_addr_a = 4;
    #1;
    push(1); chk("err_set", ren_err);
    push(0); chk("err_tag_r4", rd_tag_a);
    push(0); chk("err_busy", busy_count);
    cyc();
    cyc();
    push(1); chk("err_sticky", ren_err);

    // same-cycle CDB vs read port
    ren(2, 5);
    cyc();
    rd_addr_b = 2;
    cdb(5, 16'h00AA);
    #1;
`ifdef BANCO_CDB_BYPASS_EN
    push(16'h00AA); chk("byp_data_now", rd_data_b);
    push(0);        chk("byp_tag_now", rd_tag_b);
`else
    push(16'h4242); chk("byp_data_now", rd_data_b);
    push(5);        chk("byp_tag_now", rd_tag_b);
`endif
    cyc();
    push(16'h00AA); chk("byp_data_next", rd_data_b);
    push(0);        chk("byp_tag_next", rd_tag_b);

    // busy_count reaches NREGS
    for (int r = 0; r < 8; r++) begin
      ren(3'(r), 3'((r % 7) + 1));
      cyc();
    end
    push(8); chk("busy_full", busy_count);

    // reset clears error and table
    reset_n = 1'b0;
    cyc();
    reset_n = 1'b1;
    #1;
    push(0); chk("rst2_err", ren_err);
    push(0); chk("rst2_busy", busy_count);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
